// File: rtl/gnn_mlp_layer.sv
// Fully connected GNN MLP layer: N_OUT parallel MAC lanes, one input feature per cycle,
// then per-lane ReLU/saturation of the held accumulators until the consumer accepts the result.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a vector
// MAC   | accumulating feature k into every lane, one feature per cycle
// HOLD  | out_valid=1, accumulators frozen until out_ready
module gnn_mlp_layer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int IN_W  = 7,
  parameter int W_W   = 5,
  parameter int ACC_W = 21,
  parameter int OUT_W = 13,
  parameter int RELU  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN*IN_W-1:0]          in_data,
  input  logic [N_IN*N_OUT*W_W-1:0]     w_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT*OUT_W-1:0]        out_data,
  output logic [N_OUT*ACC_W-1:0]        out_acc,
  output logic                          busy
);

  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = IN_W + W_W;
  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  if ((ACC_W < IN_W + W_W + $clog2(N_IN)) || (OUT_W > ACC_W)) begin : g_param_check
    $error("gnn_mlp_layer: ACC_W must cover the full dot product and OUT_W must not exceed ACC_W");
  end

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t                      state;
  logic [N_IN*IN_W-1:0]        x_reg;
  logic [N_IN*N_OUT*W_W-1:0]   w_reg;
  logic [KW-1:0]               k;
  logic signed [ACC_W-1:0]     acc      [N_OUT];
  logic signed [ACC_W-1:0]     prod_ext [N_OUT];
  logic signed [IN_W-1:0]      xk;

  assign xk = x_reg[int'(k)*IN_W +: IN_W];

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    logic signed [W_W-1:0]   wk;
    logic signed [PW-1:0]    prod;
    logic signed [OUT_W-1:0] conv;

    assign wk          = w_reg[(j*N_IN + int'(k))*W_W +: W_W];
    assign prod        = xk * wk;
    assign prod_ext[j] = ACC_W'(prod);

    // Conversion reads the frozen accumulator, so out_data is stable through HOLD.
    always_comb begin
      conv = acc[j][OUT_W-1:0];
      if (RELU != 0 && acc[j] < 0)
        conv = '0;
      else if (acc[j] > SAT_MAX)
        conv = SAT_MAX[OUT_W-1:0];
      else if (acc[j] < SAT_MIN)
        conv = SAT_MIN[OUT_W-1:0];
    end

    assign out_data[j*OUT_W +: OUT_W] = conv;
    assign out_acc[j*ACC_W +: ACC_W]  = acc[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      x_reg     <= '0;
      w_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_reg    <= in_data;
            w_reg    <= w_data;
            k        <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + prod_ext[j];
          if (k == K_LAST) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
